// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: state encoding, opcodes, bus
// source codes, C-bus write-enable bit positions and ALU operation codes.
// Optional feature macro: CU_MEM_WAIT_EN adds the memory wait state S_MW.
package cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_DEC,
    S_O1, S_O2, S_O3, S_O4, S_O5,
    S_EXE, S_HALT
`ifdef CU_MEM_WAIT_EN
    , S_MW
`endif
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVR  = 4'h3;
  localparam logic [3:0] OP_MVAC = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_JUMP = 4'h8;
  localparam logic [3:0] OP_JMPZ = 4'h9;
  localparam logic [3:0] OP_END  = 4'hF;

  localparam logic [3:0] SEL_DR = 4'd0;
  localparam logic [3:0] SEL_R1 = 4'd1;
  localparam logic [3:0] SEL_R2 = 4'd2;
  localparam logic [3:0] SEL_R3 = 4'd3;
  localparam logic [3:0] SEL_RA = 4'd4;
  localparam logic [3:0] SEL_RB = 4'd5;
  localparam logic [3:0] SEL_RC = 4'd6;
  localparam logic [3:0] SEL_AC = 4'd7;
  localparam logic [3:0] SEL_PC = 4'd8;

  localparam int CB_PC = 9;
  localparam int CB_RA = 8;
  localparam int CB_RB = 7;
  localparam int CB_RC = 6;
  localparam int CB_R1 = 5;
  localparam int CB_R2 = 4;
  localparam int CB_R3 = 3;
  localparam int CB_DR = 2;
  localparam int CB_AR = 1;
  localparam int CB_AC = 0;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Register-indexed opcodes only know registers 0..8; 0xA-0xE are undefined.
  function automatic logic is_illegal(input logic [3:0] op, input logic [3:0] r);
    logic bad;
    bad = 1'b0;
    if (op >= 4'hA && op <= 4'hE) bad = 1'b1;
    else if ((op == OP_MVR || op == OP_MVAC || op == OP_ADD || op == OP_SUB) && r > 4'd8)
      bad = 1'b1;
    return bad;
  endfunction

  // One-hot C-bus write enable for the register with bus code r.
  function automatic logic [9:0] reg_we_mask(input logic [3:0] r);
    logic [9:0] m;
    m = '0;
    case (r)
      SEL_DR: m[CB_DR] = 1'b1;
      SEL_R1: m[CB_R1] = 1'b1;
      SEL_R2: m[CB_R2] = 1'b1;
      SEL_R3: m[CB_R3] = 1'b1;
      SEL_RA: m[CB_RA] = 1'b1;
      SEL_RB: m[CB_RB] = 1'b1;
      SEL_RC: m[CB_RC] = 1'b1;
      SEL_AC: m[CB_AC] = 1'b1;
      SEL_PC: m[CB_PC] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational output decode: turns the current state plus the opcode and
// register index into register-file strobes, bus select and ALU operation.
// Optional feature macro: CU_MEM_WAIT_EN (adds decode of the S_MW state).
module cu_decode
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic [3:0] r,
`ifdef CU_MEM_WAIT_EN
  input  logic       mw_write,
`endif
  output logic       ldir,
  output logic       pc_inc,
  output logic       ac_inc,
  output logic       ra_inc,
  output logic       rb_inc,
  output logic       rc_inc,
  output logic       read,
  output logic       write,
  output logic [9:0] cbus,
  output logic [3:0] select,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  // Per-state micro-operations; everything defaults to idle values first.
  always_comb begin
    ldir    = 1'b0;
    pc_inc  = 1'b0;
    ac_inc  = 1'b0;
    ra_inc  = 1'b0;
    rb_inc  = 1'b0;
    rc_inc  = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    cbus    = '0;
    select  = SEL_DR;
    alu_op  = ALU_PASS;
    illegal = 1'b0;
    busy    = (state != S_IDLE) && (state != S_HALT);
    halted  = (state == S_HALT);
    case (state)
      S_F1, S_O1: begin
        select      = SEL_PC;
        cbus[CB_AR] = 1'b1;
      end
      S_F2: begin
        read   = 1'b1;
        pc_inc = 1'b1;
      end
      S_F3: ldir = 1'b1;
      S_DEC: illegal = is_illegal(op, r);
      S_O2: begin
        read   = 1'b1;
        pc_inc = (op == OP_LDAC) || (op == OP_STAC);
      end
      S_O3: begin
        select = SEL_DR;
        if (op == OP_JUMP || op == OP_JMPZ) cbus[CB_PC] = 1'b1;
        else cbus[CB_AR] = 1'b1;
      end
      S_O4: begin
        if (op == OP_STAC) begin
          select      = SEL_AC;
          cbus[CB_DR] = 1'b1;
        end else begin
          read = 1'b1;
        end
      end
      S_O5: begin
        if (op == OP_STAC) begin
          write = 1'b1;
        end else begin
          select      = SEL_DR;
          alu_op      = ALU_PASS;
          cbus[CB_AC] = 1'b1;
        end
      end
      S_EXE: begin
        case (op)
          OP_MVR: begin
            select      = r;
            cbus[CB_AC] = 1'b1;
          end
          OP_MVAC: begin
            select = SEL_AC;
            cbus   = reg_we_mask(r);
          end
          OP_ADD: begin
            select      = r;
            alu_op      = ALU_ADD;
            cbus[CB_AC] = 1'b1;
          end
          OP_SUB: begin
            select      = r;
            alu_op      = ALU_SUB;
            cbus[CB_AC] = 1'b1;
          end
          OP_INC: begin
            case (r)
              SEL_RA: ra_inc = 1'b1;
              SEL_RB: rb_inc = 1'b1;
              SEL_RC: rc_inc = 1'b1;
              SEL_AC: ac_inc = 1'b1;
              SEL_PC: pc_inc = 1'b1;
              default: ;
            endcase
          end
          OP_JMPZ: pc_inc = 1'b1;
          default: ;
        endcase
      end
`ifdef CU_MEM_WAIT_EN
      S_MW: begin
        read  = !mw_write;
        write = mw_write;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit top: state register, opcode/index latch and next-state logic;
// output decode lives in cu_decode.
// Optional feature macro: CU_MEM_WAIT_EN inserts a wait state S_MW after
// every memory read/write state.
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       z_flag,
  output logic       LDIR,
  output logic       PC_INC,
  output logic       AC_INC,
  output logic       RA_INC,
  output logic       RB_INC,
  output logic       RC_INC,
  output logic       read,
  output logic       write,
  output logic [9:0] C_bus_ctrl_sig,
  output logic [3:0] select,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  state_t     state_q, state_d, after_mem;
  logic [3:0] op_q, r_q, op_eff, r_eff;
  logic       mem_state;

  // In DEC the IR is decoded straight from instr; afterwards the latched copy is used.
  assign op_eff = (state_q == S_DEC) ? instr[7:4] : op_q;
  assign r_eff  = (state_q == S_DEC) ? instr[3:0] : r_q;

  // State register and instruction latch (captured on the edge leaving DEC).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DEC) begin
        op_q <= instr[7:4];
        r_q  <= instr[3:0];
      end
    end
  end

`ifdef CU_MEM_WAIT_EN
  state_t mw_ret_q;
  logic   mw_write;

  // Remembers where to resume after the memory wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mw_ret_q <= S_IDLE;
    else if (mem_state) mw_ret_q <= after_mem;
  end

  assign mw_write = (mw_ret_q == S_F1);
`endif

  // Next-state logic; memory states route through S_MW when the wait is enabled.
  always_comb begin
    state_d   = state_q;
    mem_state = 1'b0;
    after_mem = S_F1;
    case (state_q)
      S_IDLE: if (start) state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2: begin
        mem_state = 1'b1;
        after_mem = S_F3;
      end
      S_F3:   state_d = S_DEC;
      S_DEC: begin
        if (is_illegal(instr[7:4], instr[3:0])) begin
          state_d = S_F1;
        end else begin
          case (instr[7:4])
            OP_LDAC, OP_STAC, OP_JUMP:               state_d = S_O1;
            OP_JMPZ:                                 state_d = z_flag ? S_O1 : S_EXE;
            OP_MVR, OP_MVAC, OP_ADD, OP_SUB, OP_INC: state_d = S_EXE;
            OP_END:                                  state_d = S_HALT;
            default:                                 state_d = S_F1;
          endcase
        end
      end
      S_O1:   state_d = S_O2;
      S_O2: begin
        mem_state = 1'b1;
        after_mem = S_O3;
      end
      S_O3:   state_d = (op_q == OP_JUMP || op_q == OP_JMPZ) ? S_F1 : S_O4;
      S_O4: begin
        if (op_q == OP_LDAC) begin
          mem_state = 1'b1;
          after_mem = S_O5;
        end else begin
          state_d = S_O5;
        end
      end
      S_O5: begin
        if (op_q == OP_STAC) begin
          mem_state = 1'b1;
          after_mem = S_F1;
        end else begin
          state_d = S_F1;
        end
      end
      S_EXE:  state_d = S_F1;
      S_HALT: state_d = S_HALT;
`ifdef CU_MEM_WAIT_EN
      S_MW:   state_d = mw_ret_q;
`endif
      default: state_d = S_IDLE;
    endcase
    if (mem_state) begin
`ifdef CU_MEM_WAIT_EN
      state_d = S_MW;
`else
      state_d = after_mem;
`endif
    end
  end

  cu_decode u_decode (
    .state    (state_q),
    .op       (op_eff),
    .r        (r_eff),
`ifdef CU_MEM_WAIT_EN
    .mw_write (mw_write),
`endif
    .ldir     (LDIR),
    .pc_inc   (PC_INC),
    .ac_inc   (AC_INC),
    .ra_inc   (RA_INC),
    .rb_inc   (RB_INC),
    .rc_inc   (RC_INC),
    .read     (read),
    .write    (write),
    .cbus     (C_bus_ctrl_sig),
    .select   (select),
    .alu_op   (alu_op),
    .busy     (busy),
    .halted   (halted),
    .illegal  (illegal)
  );

endmodule
